// File: rtl/alarm_sched.sv
// Multi-slot alarm controller: button edit flow, one shared comparator scanned per minute, ring/dismiss/timeout.
// Optional snooze support is compiled in when SNOOZE_EN is defined.
module alarm_sched #(
  parameter int NUM_SLOTS  = 4,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          newclk,
  input  logic          rst_n,
  input  logic          tick_1hz,
  input  logic [4:0]    hour,
  input  logic [5:0]    minute,
  input  logic [5:0]    second,
  input  logic          middle,
  input  logic          btn_up,
  input  logic          btn_down,
  output logic [2:0]    alarm_mode,
  output logic [SW-1:0] edit_slot,
  output logic [4:0]    edit_hour,
  output logic [5:0]    edit_minute,
  output logic          edit_en,
  output logic          ring,
  output logic [SW-1:0] ring_slot
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    EHOUR = 3'd2,
    EMIN  = 3'd3,
    EEN   = 3'd4,
    RING  = 3'd5
  } state_t;

`ifdef SNOOZE_EN
  localparam logic [3:0] SCAN_LAST = 4'(NUM_SLOTS);
`else
  localparam logic [3:0] SCAN_LAST = 4'(NUM_SLOTS - 1);
`endif

  state_t        state;
  logic          mid_q, up_q, down_q;
  logic [4:0]    slot_hour [NUM_SLOTS];
  logic [5:0]    slot_min  [NUM_SLOTS];
  logic          slot_en   [NUM_SLOTS];
  logic          scanning;
  logic [3:0]    scan_idx;
  logic [4:0]    snap_hour;
  logic [5:0]    snap_min;
  logic [7:0]    ring_cnt;

  logic          mid_e, up_act, down_act, timeout, slot_hit;
  logic [SW-1:0] scan_slot, slot_inc, slot_dec;

  // Up and down edges in the same cycle cancel each other.
  assign mid_e    = middle & ~mid_q;
  assign up_act   = btn_up & ~up_q & ~(btn_down & ~down_q);
  assign down_act = btn_down & ~down_q & ~(btn_up & ~up_q);

  assign slot_inc  = (edit_slot == SW'(NUM_SLOTS - 1)) ? '0 : edit_slot + SW'(1);
  assign slot_dec  = (edit_slot == '0) ? SW'(NUM_SLOTS - 1) : edit_slot - SW'(1);
  assign scan_slot = scan_idx[SW-1:0];
  assign slot_hit  = scanning && (scan_idx < 4'(NUM_SLOTS)) && slot_en[scan_slot] &&
                     (slot_hour[scan_slot] == snap_hour) && (slot_min[scan_slot] == snap_min);
  assign timeout   = tick_1hz && (({1'b0, ring_cnt} + 9'd1) == 9'(RING_SECS));
  assign alarm_mode = state;

`ifdef SNOOZE_EN
  logic          snz_valid, snz_hit, snz_carry;
  logic [4:0]    snz_hour, tgt_hour;
  logic [5:0]    snz_min, tgt_min;
  logic [SW-1:0] snz_slot;
  logic [6:0]    min_sum;

  // The snooze slot is checked one cycle after the last real slot.
  assign snz_hit   = scanning && (scan_idx == 4'(NUM_SLOTS)) && snz_valid &&
                     (snz_hour == snap_hour) && (snz_min == snap_min);
  assign min_sum   = 7'(snap_min) + 7'(SNOOZE_MIN);
  assign snz_carry = (min_sum >= 7'd60);
  assign tgt_min   = snz_carry ? 6'(min_sum - 7'd60) : min_sum[5:0];
  assign tgt_hour  = !snz_carry ? snap_hour : ((snap_hour == 5'd23) ? 5'd0 : snap_hour + 5'd1);
`endif

  always_ff @(posedge newclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mid_q       <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      edit_slot   <= '0;
      edit_hour   <= '0;
      edit_minute <= '0;
      edit_en     <= 1'b0;
      ring        <= 1'b0;
      ring_slot   <= '0;
      scanning    <= 1'b0;
      scan_idx    <= '0;
      snap_hour   <= '0;
      snap_min    <= '0;
      ring_cnt    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_hour[i] <= '0;
        slot_min[i]  <= '0;
        slot_en[i]   <= 1'b0;
      end
`ifdef SNOOZE_EN
      snz_valid <= 1'b0;
      snz_hour  <= '0;
      snz_min   <= '0;
      snz_slot  <= '0;
`endif
    end else begin
      mid_q  <= middle;
      up_q   <= btn_up;
      down_q <= btn_down;
      case (state)
        IDLE: begin
          // Entering edit abandons any scan still in flight.
          if (mid_e) begin
            state       <= SEL;
            scanning    <= 1'b0;
            edit_slot   <= '0;
            edit_hour   <= slot_hour[0];
            edit_minute <= slot_min[0];
            edit_en     <= slot_en[0];
          end else if (scanning) begin
            if (slot_hit) begin
              state     <= RING;
              ring      <= 1'b1;
              ring_slot <= scan_slot;
              ring_cnt  <= '0;
              scanning  <= 1'b0;
`ifdef SNOOZE_EN
            end else if (snz_hit) begin
              state     <= RING;
              ring      <= 1'b1;
              ring_slot <= snz_slot;
              ring_cnt  <= '0;
              scanning  <= 1'b0;
`endif
            end else if (scan_idx == SCAN_LAST) begin
              scanning <= 1'b0;
            end else begin
              scan_idx <= scan_idx + 4'd1;
            end
          end else if (tick_1hz && (second == 6'd0)) begin
            scanning  <= 1'b1;
            scan_idx  <= '0;
            snap_hour <= hour;
            snap_min  <= minute;
          end
        end
        SEL: begin
          if (mid_e) begin
            state <= EHOUR;
          end else if (up_act) begin
            edit_slot   <= slot_inc;
            edit_hour   <= slot_hour[slot_inc];
            edit_minute <= slot_min[slot_inc];
            edit_en     <= slot_en[slot_inc];
          end else if (down_act) begin
            edit_slot   <= slot_dec;
            edit_hour   <= slot_hour[slot_dec];
            edit_minute <= slot_min[slot_dec];
            edit_en     <= slot_en[slot_dec];
          end
        end
        EHOUR: begin
          if (mid_e) state <= EMIN;
          else if (up_act) edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
          else if (down_act) edit_hour <= (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
        end
        EMIN: begin
          if (mid_e) state <= EEN;
          else if (up_act) edit_minute <= (edit_minute == 6'd59) ? 6'd0 : edit_minute + 6'd1;
          else if (down_act) edit_minute <= (edit_minute == 6'd0) ? 6'd59 : edit_minute - 6'd1;
        end
        EEN: begin
          if (mid_e) begin
            state                <= IDLE;
            slot_hour[edit_slot] <= edit_hour;
            slot_min[edit_slot]  <= edit_minute;
            slot_en[edit_slot]   <= edit_en;
          end else if (up_act || down_act) begin
            edit_en <= ~edit_en;
          end
        end
        RING: begin
          if (mid_e || timeout) begin
            state <= IDLE;
            ring  <= 1'b0;
`ifdef SNOOZE_EN
            snz_valid <= 1'b0;
          end else if (up_act) begin
            state     <= IDLE;
            ring      <= 1'b0;
            snz_valid <= 1'b1;
            snz_hour  <= tgt_hour;
            snz_min   <= tgt_min;
            snz_slot  <= ring_slot;
`endif
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sched.sv
// Randomized bench for alarm_sched against a press-level reference model of the alarm controller.
module tb_alarm_sched;
  localparam int N  = 4;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int SW = 2;

  logic          newclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_1hz = 1'b0;
  logic [4:0]    hour = '0;
  logic [5:0]    minute = '0;
  logic [5:0]    second = '0;
  logic          middle = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0]    alarm_mode;
  logic [SW-1:0] edit_slot, ring_slot;
  logic [4:0]    edit_hour;
  logic [5:0]    edit_minute;
  logic          edit_en, ring;

  alarm_sched #(.NUM_SLOTS(N), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .newclk(newclk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .hour(hour), .minute(minute), .second(second),
    .middle(middle), .btn_up(btn_up), .btn_down(btn_down),
    .alarm_mode(alarm_mode), .edit_slot(edit_slot), .edit_hour(edit_hour),
    .edit_minute(edit_minute), .edit_en(edit_en), .ring(ring), .ring_slot(ring_slot)
  );

  always #5 newclk = ~newclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: slot table, edit view, ring and snooze status.
  int m_h[N], m_m[N];
  bit m_e[N];
  int m_mode, m_es, m_eh, m_em, m_rslot, m_rcnt, m_fh, m_fm;
  bit m_een, m_ring, m_sv;
  int m_sh, m_sm, m_ss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge newclk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_h[i] = 0; m_m[i] = 0; m_e[i] = 0;
    end
    m_mode = 0; m_es = 0; m_eh = 0; m_em = 0; m_een = 0;
    m_ring = 0; m_rslot = 0; m_rcnt = 0; m_sv = 0;
  endfunction

  function automatic void load_edit(input int s);
    m_es = s; m_eh = m_h[s]; m_em = m_m[s]; m_een = m_e[s];
  endfunction

  // b: 0 middle, 1 up, 2 down, 3 up+down together.
  function automatic void model_press(input int b);
    int total;
    case (m_mode)
      0: if (b == 0) begin m_mode = 1; load_edit(0); end
      1: if (b == 0) m_mode = 2;
         else if (b == 1) load_edit((m_es + 1) % N);
         else if (b == 2) load_edit((m_es + N - 1) % N);
      2: if (b == 0) m_mode = 3;
         else if (b == 1) m_eh = (m_eh + 1) % 24;
         else if (b == 2) m_eh = (m_eh + 23) % 24;
      3: if (b == 0) m_mode = 4;
         else if (b == 1) m_em = (m_em + 1) % 60;
         else if (b == 2) m_em = (m_em + 59) % 60;
      4: if (b == 0) begin
           m_h[m_es] = m_eh; m_m[m_es] = m_em; m_e[m_es] = m_een; m_mode = 0;
         end else if (b == 1 || b == 2) m_een = !m_een;
      5: if (b == 0) begin
           m_mode = 0; m_ring = 0; m_sv = 0;
         end
`ifdef SNOOZE_EN
         else if (b == 1) begin
           total = m_fh * 60 + m_fm + SM;
           m_sh = (total / 60) % 24; m_sm = total % 60; m_ss = m_rslot;
           m_sv = 1; m_mode = 0; m_ring = 0;
         end
`endif
      default: ;
    endcase
    total = 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_mode"}, 32'(alarm_mode), 32'(m_mode));
    check({tag, "_eslot"}, 32'(edit_slot), 32'(m_es));
    check({tag, "_ehour"}, 32'(edit_hour), 32'(m_eh));
    check({tag, "_emin"}, 32'(edit_minute), 32'(m_em));
    check({tag, "_een"}, 32'(edit_en), 32'(m_een));
    check({tag, "_ring"}, 32'(ring), 32'(m_ring));
    if (m_ring) check({tag, "_rslot"}, 32'(ring_slot), 32'(m_rslot));
  endtask

  task automatic press(input int b);
    middle = (b == 0);
    btn_up = (b == 1 || b == 3);
    btn_down = (b == 2 || b == 3);
    repeat ($urandom_range(1, 3)) cyc();
    middle = 0; btn_up = 0; btn_down = 0;
    cyc();
    model_press(b);
    check_outputs("press");
  endtask

  task automatic maybe_both();
    if ($urandom_range(0, 3) == 0) press(3);
  endtask

  task automatic walk(input int cur, input int tgt, input int modulo);
    int d;
    d = (tgt - cur + modulo) % modulo;
    if (d <= modulo / 2) repeat (d) press(1);
    else repeat (modulo - d) press(2);
  endtask

  task automatic program_slot(input int s, input int h, input int mi, input bit en);
    press(0);
    maybe_both();
    walk(m_es, s, N);
    press(0);
    maybe_both();
    walk(m_eh, h, 24);
    press(0);
    walk(m_em, mi, 60);
    press(0);
    maybe_both();
    if (m_een != en) press($urandom_range(1, 2));
    press(0);
  endtask

  // Trigger a scan at h:mi:00 and follow it to completion.
  task automatic do_scan(input int h, input int mi);
    int hit, sl;
    hour = 5'(h); minute = 6'(mi); second = 0; tick_1hz = 1;
    cyc();
    tick_1hz = 0; second = 1;
    hit = -1; sl = 0;
    if (m_mode == 0) begin
      for (int i = 0; i < N; i++)
        if (hit < 0 && m_e[i] && m_h[i] == h && m_m[i] == mi) begin hit = i; sl = i; end
`ifdef SNOOZE_EN
      if (hit < 0 && m_sv && m_sh == h && m_sm == mi) begin hit = N; sl = m_ss; end
`endif
    end
    if (hit >= 0) begin
      for (int k = 0; k <= hit; k++) begin
        check("scan_quiet", 32'(ring), 32'd0);
        cyc();
      end
      m_mode = 5; m_ring = 1; m_rslot = sl; m_rcnt = 0; m_fh = h; m_fm = mi;
      check("scan_ring", 32'(ring), 32'd1);
      check("scan_rslot", 32'(ring_slot), 32'(sl));
      check("scan_mode", 32'(alarm_mode), 32'd5);
    end else begin
      repeat (N + 2) cyc();
      check("scan_none_ring", 32'(ring), 32'(m_ring));
      check("scan_none_mode", 32'(alarm_mode), 32'(m_mode));
    end
  endtask

  task automatic ring_timeout();
    while (m_mode == 5) begin
      tick_1hz = 1;
      cyc();
      tick_1hz = 0;
      m_rcnt++;
      if (m_rcnt >= RS) begin m_mode = 0; m_ring = 0; m_sv = 0; end
      check("timeout_ring", 32'(ring), 32'(m_ring));
      cyc();
    end
    check("timeout_mode", 32'(alarm_mode), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, h, mi, r;
    model_reset();
    repeat (3) cyc();
    check_outputs("reset");
    check("reset_rslot", 32'(ring_slot), 32'd0);
    rst_n = 1;
    cyc();

    // Slot 2 = 07:30 enabled, stepping the slot index 0,1,2.
    press(0); press(1); press(1);
    press(0); repeat (7) press(1);
    press(0); repeat (30) press(1);
    press(0); press(1); press(0);
    check("t1_slot2_hour", 32'(m_h[2]), 32'd7);

    // Slots 1 and 3 at 07:30: lowest index wins, ring at t+3.
    program_slot(1, 7, 30, 1);
    program_slot(3, 7, 30, 1);
    do_scan(7, 30);
    check("t2_rslot", 32'(ring_slot), 32'd1);
    ring_timeout();

    // Wraps: slot 0 -> N-1, hour 23 -> 0, minute 0 -> 59.
    press(0); press(2);
    press(0); walk(m_eh, 23, 24); press(1);
    press(0); walk(m_em, 0, 60); press(2);
    press(0); press(0);

    // Trigger during edit is dropped for the whole minute.
    program_slot(0, 9, 15, 1);
    press(0); press(0);
    do_scan(9, 15);
    press(0); press(0); press(0);
    repeat (N + 3) cyc();
    check("t5_no_ring", 32'(ring), 32'd0);

    // Randomized programming, scans and ring endings.
    for (int it = 0; it < 14; it++) begin
      s = $urandom_range(0, N - 1);
      program_slot(s, $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, N - 1); h = m_h[s]; mi = m_m[s];
      end else begin
        h = $urandom_range(0, 23); mi = $urandom_range(0, 59);
      end
      do_scan(h, mi);
      if (m_mode == 5) begin
        r = $urandom_range(0, 3);
        if (r == 0) press(0);
        else if (r == 1) ring_timeout();
        else if (r == 2) begin press(2); press(0); end
        else begin
          press(1);
          if (m_mode == 0) do_scan(m_sh, m_sm);
          if (m_mode == 5) press(0);
        end
      end
    end

    rst_n = 0; cyc(); rst_n = 1; model_reset(); cyc();
    check_outputs("rst2");

`ifdef SNOOZE_EN
    program_slot(0, 23, 58, 1);
    do_scan(23, 58);
    press(1);
    check("snz_ring_off", 32'(ring), 32'd0);
    do_scan(0, 3);
    check("snz_rslot", 32'(ring_slot), 32'd0);
    press(1);
    do_scan(0, 8);
    check("snz2_ring", 32'(ring), 32'd1);
    press(0);
    do_scan(0, 13);
`endif

    // Asynchronous reset in the middle of a ring.
    program_slot(1, 7, 30, 1);
    do_scan(7, 30);
    #2 rst_n = 0;
    #1;
    check("async_ring", 32'(ring), 32'd0);
    check("async_mode", 32'(alarm_mode), 32'd0);
    #3 rst_n = 1;
    model_reset();
    cyc();
    check_outputs("post_rst");
    do_scan(7, 30);
    press(0);
    press(1);
    press(0); press(0); press(0); press(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
